prog_result_checker: RTL

- Synthesizable end-of-program monitor for the single-cycle CPU. It replaces the fixed-delay, one-register compare in the current test flow with a reusable block.
- Detects program completion in one of two ways: PC held at a self-loop for STABLE_CYCLES consecutive cycles, or a cycle budget (TIMEOUT) exhausted.
- On completion it compares up to NUM_CHK observed register values against expected values, each gated by an enable bit. It then reports a per-channel fail mask, an overall pass flag and the elapsed cycle count.
- Sits beside the cpu instance; register-file outputs and PC are wired in, and expected values come from the bench or a ROM.

---
 rtl/prog_result_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/prog_result_checker.sv
// End-of-program monitor: detects CPU halt (PC self-loop) or cycle-budget
// exhaustion, then compares observed register values against expected ones.
module prog_result_checker #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_CHK       = 4,
  parameter int unsigned TIMEOUT       = 1000,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DATA_W-1:0]           pc,
  input  logic [NUM_CHK*DATA_W-1:0]   obs_vals,
  input  logic [NUM_CHK*DATA_W-1:0]   exp_vals,
  input  logic [NUM_CHK-1:0]          chk_en,
  output logic                        busy,
  output logic                        done,
  output logic                        passed,
  output logic                        timed_out,
  output logic [NUM_CHK-1:0]          fail_mask,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int unsigned ST_W = $clog2(STABLE_CYCLES + 1);

  if (TIMEOUT >= (64'd1 << CNT_W)) begin : g_cnt_chk
    $error("prog_result_checker: TIMEOUT must be below 2**CNT_W");
  end
  if (TIMEOUT < STABLE_CYCLES) begin : g_tmo_chk
    $error("prog_result_checker: TIMEOUT must be >= STABLE_CYCLES");
  end
  if (STABLE_CYCLES < 2) begin : g_stable_chk
    $error("prog_result_checker: STABLE_CYCLES must be >= 2");
  end
  if (NUM_CHK < 1 || NUM_CHK > 32) begin : g_chk_chk
    $error("prog_result_checker: NUM_CHK must be in 1..32");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   pc_prev_q, pc_prev_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic [ST_W-1:0]     stable_q, stable_d;
  logic                timed_out_q, timed_out_d;
  logic                passed_q, passed_d;
  logic [NUM_CHK-1:0]  fail_mask_q, fail_mask_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                pc_same_c;
  logic                halt_c;
  logic                budget_c;
  logic [NUM_CHK-1:0]  mismatch_c;

  // Per-channel full-width compare, masked by enable.
  always_comb begin
    mismatch_c = '0;
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      mismatch_c[i] = chk_en[i] &
                      (obs_vals[i*DATA_W +: DATA_W] != exp_vals[i*DATA_W +: DATA_W]);
    end
  end

  assign pc_same_c = (pc == pc_prev_q);
  assign halt_c    = pc_same_c && (stable_q == ST_W'(STABLE_CYCLES - 1));
  assign budget_c  = (cycle_count_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    pc_prev_d     = pc_prev_q;
    cycle_count_d = cycle_count_q;
    stable_d      = stable_q;
    timed_out_d   = timed_out_q;
    passed_d      = passed_q;
    fail_mask_d   = fail_mask_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RUN;
          pc_prev_d     = pc;
          cycle_count_d = '0;
          stable_d      = '0;
          timed_out_d   = 1'b0;
          fail_mask_d   = '0;
          passed_d      = 1'b0;
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        pc_prev_d     = pc;
        if (!pc_same_c) begin
          stable_d = '0;
        end else if (stable_q != ST_W'(STABLE_CYCLES)) begin
          stable_d = stable_q + ST_W'(1);
        end
        // Halt has priority over an expiring budget in the same cycle.
        if (halt_c) begin
          state_d     = S_CHECK;
          timed_out_d = 1'b0;
        end else if (budget_c) begin
          state_d     = S_CHECK;
          timed_out_d = 1'b1;
        end
      end
      S_CHECK: begin
        fail_mask_d = mismatch_c;
        passed_d    = ~(|mismatch_c) & ~timed_out_q;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_prev_q     <= '0;
      cycle_count_q <= '0;
      stable_q      <= '0;
      timed_out_q   <= 1'b0;
      passed_q      <= 1'b0;
      fail_mask_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_prev_q     <= pc_prev_d;
      cycle_count_q <= cycle_count_d;
      stable_q      <= stable_d;
      timed_out_q   <= timed_out_d;
      passed_q      <= passed_d;
      fail_mask_q   <= fail_mask_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign passed      = passed_q;
  assign timed_out   = timed_out_q;
  assign fail_mask   = fail_mask_q;
  assign cycle_count = cycle_count_q;

endmodule
